hdmi_cfg_sequencer: RTL and testbench

AXI4-Lite configuration master that programs the hdmi_controller register file from a small external table after a start pulse. Each entry is written, then optionally read back and compared. The block stops on the first failure. It sits between the system control logic and the hdmi_controller S_AXI port, replacing the BFM master used in simulation.

---
 rtl/hdmi_cfg_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_hdmi_cfg_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_cfg_sequencer
// Brief    : AXI4-Lite master that writes a small external register table into
//            the hdmi_controller, with optional readback compare.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_cfg_sequencer #(
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] C_BASE_ADDR        = 32'h0000_0000,
    parameter int          C_NUM_REGS         = 4,
    parameter int          C_TIMEOUT          = 255
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            start,
    input  logic                            verify_en,
    output logic [3:0]                      tbl_idx,
    input  logic [7:0]                      tbl_offset,
    input  logic [31:0]                     tbl_wdata,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [1:0]                      err_code,
    output logic [3:0]                      err_idx,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int                          AW         = C_M_AXI_ADDR_WIDTH;
    localparam int                          DW         = C_M_AXI_DATA_WIDTH;
    localparam logic [AW-1:0]               C_BASE     = AW'(C_BASE_ADDR);
    localparam logic [3:0]                  C_LAST_IDX = 4'(C_NUM_REGS - 1);
    localparam logic [7:0]                  C_TMO_LAST = 8'(C_TIMEOUT - 1);

    localparam logic [1:0] C_ERR_RESP     = 2'b01;
    localparam logic [1:0] C_ERR_MISMATCH = 2'b10;
    localparam logic [1:0] C_ERR_TIMEOUT  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_WADDR = 4'd2,
        S_WRESP = 4'd3,
        S_RADDR = 4'd4,
        S_RDATA = 4'd5,
        S_NEXT  = 4'd6,
        S_DONE  = 4'd7,
        S_ERROR = 4'd8
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      w_err_code;
    logic [3:0]      r_idx;
    logic            r_verify;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_aw_done;
    logic            r_w_done;
    logic [7:0]      r_timer;
    logic            r_error;
    logic [1:0]      r_err_code;
    logic [3:0]      r_err_idx;

    logic            w_aw_ok;
    logic            w_w_ok;
    logic            w_tmo;
    logic            w_accept;
    logic [AW-1:0]   w_offset;
    logic            w_unused_ok;

    // Offset is word aligned: the two low bits are deliberately dropped.
    assign w_offset    = {{(AW-8){1'b0}}, tbl_offset[7:2], 2'b00};
    assign w_unused_ok = &{1'b0, tbl_offset[1:0]};

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_aw_ok  = r_aw_done || M_AXI_AWREADY;
    assign w_w_ok   = r_w_done  || M_AXI_WREADY;
    assign w_tmo    = (r_timer == C_TMO_LAST);

    always_comb begin
        w_state_next = r_state;
        w_err_code   = 2'b00;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_WADDR;
            S_WADDR: begin
                if (w_aw_ok && w_w_ok) begin
                    w_state_next = S_WRESP;
                end else if (w_tmo) begin
                    w_state_next = S_ERROR;
                    w_err_code   = C_ERR_TIMEOUT;
                end
            end
            S_WRESP: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        w_state_next = S_ERROR;
                        w_err_code   = C_ERR_RESP;
                    end else begin
                        w_state_next = r_verify ? S_RADDR : S_NEXT;
                    end
                end else if (w_tmo) begin
                    w_state_next = S_ERROR;
                    w_err_code   = C_ERR_TIMEOUT;
                end
            end
            S_RADDR: begin
                if (M_AXI_ARREADY) begin
                    w_state_next = S_RDATA;
                end else if (w_tmo) begin
                    w_state_next = S_ERROR;
                    w_err_code   = C_ERR_TIMEOUT;
                end
            end
            S_RDATA: begin
                if (M_AXI_RVALID) begin
                    if (M_AXI_RRESP != 2'b00) begin
                        w_state_next = S_ERROR;
                        w_err_code   = C_ERR_RESP;
                    end else if (M_AXI_RDATA != r_wdata) begin
                        w_state_next = S_ERROR;
                        w_err_code   = C_ERR_MISMATCH;
                    end else begin
                        w_state_next = S_NEXT;
                    end
                end else if (w_tmo) begin
                    w_state_next = S_ERROR;
                    w_err_code   = C_ERR_TIMEOUT;
                end
            end
            S_NEXT:  w_state_next = (r_idx == C_LAST_IDX) ? S_DONE : S_LOAD;
            S_DONE:  w_state_next = S_IDLE;
            S_ERROR: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state    <= S_IDLE;
            r_idx      <= 4'd0;
            r_verify   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_timer    <= 8'd0;
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
            r_err_idx  <= 4'd0;
        end else begin
            r_state <= w_state_next;

            // Timer restarts whenever the FSM moves, so each wait state gets a full budget.
            if (w_state_next != r_state) begin
                r_timer <= 8'd0;
            end else begin
                r_timer <= r_timer + 8'd1;
            end

            if (w_accept) begin
                r_verify   <= verify_en;
                r_idx      <= 4'd0;
                r_error    <= 1'b0;
                r_err_code <= 2'b00;
                r_err_idx  <= 4'd0;
            end

            if (r_state == S_LOAD) begin
                r_addr    <= C_BASE + w_offset;
                r_wdata   <= DW'(tbl_wdata);
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end

            if (r_state == S_WADDR) begin
                r_aw_done <= r_aw_done || M_AXI_AWREADY;
                r_w_done  <= r_w_done  || M_AXI_WREADY;
            end

            if ((r_state == S_NEXT) && (r_idx != C_LAST_IDX)) begin
                r_idx <= r_idx + 4'd1;
            end

            if (r_state == S_DONE) begin
                r_idx <= 4'd0;
            end

            if (w_state_next == S_ERROR) begin
                r_error    <= 1'b1;
                r_err_code <= w_err_code;
                r_err_idx  <= r_idx;
            end
        end
    end

    assign tbl_idx  = r_idx;
    assign busy     = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
    assign done     = (r_state == S_DONE);
    assign error    = r_error;
    assign err_code = r_err_code;
    assign err_idx  = r_err_idx;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = (r_state == S_WADDR) && !r_aw_done;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = (r_state == S_WADDR) && !r_w_done;
    assign M_AXI_BREADY  = (r_state == S_WRESP);
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (r_state == S_RADDR);
    assign M_AXI_RREADY  = (r_state == S_RDATA);

endmodule
`default_nettype wire

// File: tb/tb_hdmi_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_cfg_sequencer
// Brief    : Directed self-checking bench with an AXI4-Lite slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_cfg_sequencer;

    logic        tb_ACLK;
    logic        ARESETN;
    logic        start;
    logic        verify_en;
    logic [3:0]  tbl_idx;
    logic [7:0]  tbl_offset;
    logic [31:0] tbl_wdata;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [3:0]  err_idx;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;

    hdmi_cfg_sequencer #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .C_BASE_ADDR        (32'h43C0_0000),
        .C_NUM_REGS         (4),
        .C_TIMEOUT          (8)
    ) dut (
        .ACLK          (tb_ACLK),
        .ARESETN       (ARESETN),
        .start         (start),
        .verify_en     (verify_en),
        .tbl_idx       (tbl_idx),
        .tbl_offset    (tbl_offset),
        .tbl_wdata     (tbl_wdata),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_code      (err_code),
        .err_idx       (err_idx),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    initial begin
        tb_ACLK = 1'b0;
        forever #5 tb_ACLK = ~tb_ACLK;
    end

    // ---------------- external table ROM ----------------
    logic [7:0]  rom_off  [0:3];
    logic [31:0] rom_data [0:3];
    assign tbl_offset = rom_off[tbl_idx[1:0]];
    assign tbl_wdata  = rom_data[tbl_idx[1:0]];

    // ---------------- slave model ----------------
    int          aw_delay, w_delay, bad_b_idx;
    logic        ar_ready_en, stuck_en;
    logic        s_aw_got, s_w_got;
    logic [31:0] s_awaddr, s_wdata;
    int          s_aw_wait, s_w_wait;
    logic [31:0] mem [0:15];

    wire        s_aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
    wire        s_w_fire  = M_AXI_WVALID && M_AXI_WREADY;
    wire [31:0] s_b_addr  = s_aw_got ? s_awaddr : M_AXI_AWADDR;
    wire [31:0] s_b_data  = s_w_got ? s_wdata : M_AXI_WDATA;

    assign M_AXI_AWREADY = !s_aw_got && !M_AXI_BVALID && (s_aw_wait >= aw_delay);
    assign M_AXI_WREADY  = !s_w_got && !M_AXI_BVALID && (s_w_wait >= w_delay);
    assign M_AXI_ARREADY = ar_ready_en && !M_AXI_RVALID;

    always @(posedge tb_ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            s_aw_got <= 1'b0; s_w_got <= 1'b0;
            s_awaddr <= '0;   s_wdata <= '0;
            s_aw_wait <= 0;   s_w_wait <= 0;
            M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
            M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else begin
            if (s_aw_fire) begin
                s_aw_got <= 1'b1; s_awaddr <= M_AXI_AWADDR; s_aw_wait <= 0;
            end else if (M_AXI_AWVALID) begin
                s_aw_wait <= s_aw_wait + 1;
            end
            if (s_w_fire) begin
                s_w_got <= 1'b1; s_wdata <= M_AXI_WDATA; s_w_wait <= 0;
            end else if (M_AXI_WVALID) begin
                s_w_wait <= s_w_wait + 1;
            end
            if ((s_aw_got || s_aw_fire) && (s_w_got || s_w_fire)) begin
                M_AXI_BVALID <= 1'b1;
                M_AXI_BRESP  <= (int'(s_b_addr[5:2]) == bad_b_idx) ? 2'b10 : 2'b00;
                mem[s_b_addr[5:2]] <= s_b_data;
                s_aw_got <= 1'b0;
                s_w_got  <= 1'b0;
            end else if (M_AXI_BVALID && M_AXI_BREADY) begin
                M_AXI_BVALID <= 1'b0;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                M_AXI_RVALID <= 1'b1;
                M_AXI_RRESP  <= 2'b00;
                M_AXI_RDATA  <= (stuck_en && M_AXI_ARADDR[5:2] == 4'd2) ? 32'hdead_0010
                                                                       : mem[M_AXI_ARADDR[5:2]];
            end else if (M_AXI_RVALID && M_AXI_RREADY) begin
                M_AXI_RVALID <= 1'b0;
            end
        end
    end

    // ---------------- bus monitor ----------------
    int          aw_hs, w_hs, ar_hs, aw_vc, w_vc, ar_vc, bready_early, busy_c, done_c;
    logic [31:0] aw_log [0:63];

    initial begin
        aw_hs = 0; w_hs = 0; ar_hs = 0; aw_vc = 0; w_vc = 0; ar_vc = 0;
        bready_early = 0; busy_c = 0; done_c = 0;
    end

    always @(negedge tb_ACLK) begin
        if (M_AXI_AWVALID) aw_vc++;
        if (M_AXI_WVALID)  w_vc++;
        if (M_AXI_ARVALID) ar_vc++;
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            aw_log[aw_hs % 64] = M_AXI_AWADDR;
            aw_hs++;
        end
        if (M_AXI_WVALID && M_AXI_WREADY)   w_hs++;
        if (M_AXI_ARVALID && M_AXI_ARREADY) ar_hs++;
        if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) bready_early++;
        if (busy) busy_c++;
        if (done) done_c++;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    int b_aw_hs, b_w_hs, b_ar_hs, b_aw_vc, b_w_vc, b_ar_vc, b_bready, b_busy, b_done;

    // Pulse start, optionally pulse it again while busy, wait for done/error.
    task automatic run(input logic ven, input int mid_start, input logic chk_clr);
        logic fin;
        int   cyc;
        b_aw_hs = aw_hs; b_w_hs = w_hs; b_ar_hs = ar_hs;
        b_aw_vc = aw_vc; b_w_vc = w_vc; b_ar_vc = ar_vc;
        b_bready = bready_early; b_busy = busy_c; b_done = done_c;
        verify_en = ven;
        start     = 1'b1;
        @(negedge tb_ACLK);
        start     = 1'b0;
        verify_en = 1'b0;
        if (chk_clr) check("error_cleared_on_start", error, 1'b0);
        fin = 1'b0;
        cyc = 0;
        while (!fin && cyc < 300) begin
            if (cyc == mid_start) start = 1'b1;
            @(negedge tb_ACLK);
            start = 1'b0;
            cyc++;
            if (done || error) fin = 1'b1;
        end
        check("run_finished", fin, 1'b1);
        repeat (2) @(negedge tb_ACLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=time_limit expected=finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        rom_off[0] = 8'h00; rom_data[0] = 32'h0101_FFFF;
        rom_off[1] = 8'h04; rom_data[1] = 32'habcd_0001;
        rom_off[2] = 8'h08; rom_data[2] = 32'hdead_0011;
        rom_off[3] = 8'h0C; rom_data[3] = 32'hbeef_0011;
        aw_delay = 0; w_delay = 0; bad_b_idx = -1; ar_ready_en = 1'b1; stuck_en = 1'b0;
        start = 1'b0; verify_en = 1'b0;
        ARESETN = 1'b0;
        repeat (3) @(negedge tb_ACLK);

        // Reset state
        check("rst_busy",    busy, 1'b0);
        check("rst_done",    done, 1'b0);
        check("rst_error",   error, 1'b0);
        check("rst_errcode", err_code, 2'b00);
        check("rst_tblidx",  tbl_idx, 4'd0);
        check("rst_valids",  {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 5'b0);
        check("rst_awaddr",  M_AXI_AWADDR, 32'h0);
        ARESETN = 1'b1;
        repeat (2) @(negedge tb_ACLK);

        // Basic write with verify
        run(1'b1, -1, 1'b0);
        check("t1_aw_count", aw_hs - b_aw_hs, 4);
        check("t1_ar_count", ar_hs - b_ar_hs, 4);
        check("t1_done",     done_c - b_done, 1);
        check("t1_error",    error, 1'b0);
        check("t1_busy_cyc", busy_c - b_busy, 24);
        check("t1_addr0",    aw_log[b_aw_hs % 64], 32'h43C0_0000);
        check("t1_addr3",    aw_log[(b_aw_hs + 3) % 64], 32'h43C0_000C);
        check("t1_mem2",     mem[2], 32'hdead_0011);
        check("t1_tblidx",   tbl_idx, 4'd0);

        // Verify off
        run(1'b0, -1, 1'b0);
        check("t2_ar_valid", ar_vc - b_ar_vc, 0);
        check("t2_busy_cyc", busy_c - b_busy, 16);
        check("t2_done",     done_c - b_done, 1);

        // Stuck bit on readback of entry 2
        stuck_en = 1'b1;
        run(1'b1, -1, 1'b0);
        stuck_en = 1'b0;
        check("t3_error",    error, 1'b1);
        check("t3_errcode",  err_code, 2'b10);
        check("t3_erridx",   err_idx, 4'd2);
        check("t3_aw_count", aw_hs - b_aw_hs, 3);
        check("t3_done",     done_c - b_done, 0);
        check("t3_busy",     busy, 1'b0);

        // Skewed write handshakes
        aw_delay = 3;
        run(1'b0, -1, 1'b1);
        aw_delay = 0;
        check("t4_awvalid_cyc", aw_vc - b_aw_vc, 16);
        check("t4_wvalid_cyc",  w_vc - b_w_vc, 4);
        check("t4_aw_count",    aw_hs - b_aw_hs, 4);
        check("t4_bready_early", bready_early - b_bready, 0);
        check("t4_done",        done_c - b_done, 1);

        // Bad write response on entry 1
        bad_b_idx = 1;
        run(1'b0, -1, 1'b0);
        bad_b_idx = -1;
        check("t5_errcode",  err_code, 2'b01);
        check("t5_erridx",   err_idx, 4'd1);
        check("t5_aw_count", aw_hs - b_aw_hs, 2);

        // ARREADY stuck low: timeout after 8 cycles in RADDR
        ar_ready_en = 1'b0;
        run(1'b1, -1, 1'b1);
        ar_ready_en = 1'b1;
        check("t6_error",    error, 1'b1);
        check("t6_errcode",  err_code, 2'b11);
        check("t6_erridx",   err_idx, 4'd0);
        check("t6_ar_cyc",   ar_vc - b_ar_vc, 8);
        check("t6_arvalid",  M_AXI_ARVALID, 1'b0);

        // Asynchronous reset while in WADDR
        aw_delay = 6;
        verify_en = 1'b1;
        start = 1'b1;
        @(negedge tb_ACLK);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge tb_ACLK);
            if (M_AXI_AWVALID) seen = 1'b1;
        end
        check("t7_aw_seen", seen, 1'b1);
        check("t7_awaddr",  M_AXI_AWADDR, 32'h43C0_0000);
        check("t7_prot_strb", {M_AXI_AWPROT, M_AXI_WSTRB}, 7'b000_1111);
        #2;
        ARESETN = 1'b0;
        #1;
        check("t7_rst_valids", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b00);
        check("t7_rst_busy",   busy, 1'b0);
        repeat (2) @(negedge tb_ACLK);
        ARESETN = 1'b1;
        aw_delay = 0;
        rom_off[3] = 8'h0E;
        @(negedge tb_ACLK);

        // Clean rerun with a start pulse while busy; low offset bits ignored
        run(1'b1, 5, 1'b0);
        check("t8_done",     done_c - b_done, 1);
        check("t8_aw_count", aw_hs - b_aw_hs, 4);
        check("t8_busy_cyc", busy_c - b_busy, 24);
        check("t8_error",    error, 1'b0);
        check("t8_addr3",    aw_log[(b_aw_hs + 3) % 64], 32'h43C0_000C);
        check("t8_mem3",     mem[3], 32'hbeef_0011);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
